// File: rtl/hist_eq_sequencer_if.sv
// Handshake bundle between the histogram-equalizer phase sequencer and its
// surroundings: host go/abort, the three engine start/done pairs, scratchpad
// ownership and frame status.
// master: the sequencer side. slave: host plus engines.
interface hist_eq_sequencer_if;
   logic        go;
   logic        abort;
   logic        hist_start;
   logic        hist_done;
   logic        cdf_start;
   logic        cdf_done;
   logic        map_start;
   logic        map_done;
   logic [1:0]  m2_grant;
   logic        base_offset;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        error;

   modport master (
      input  go, abort, hist_done, cdf_done, map_done,
      output hist_start, cdf_start, map_start, m2_grant,
             base_offset, busy, frame_done, frame_count, error
   );

   modport slave (
      output go, abort, hist_done, cdf_done, map_done,
      input  hist_start, cdf_start, map_start, m2_grant,
             base_offset, busy, frame_done, frame_count, error
   );
endinterface

// File: rtl/hist_eq_sequencer.sv
// hist_eq_sequencer: runs one frame through histogram count, CDF build and
// pixel remap in order. Owns each engine's start/done handshake, the m2
// scratchpad grant and the per-frame scratchpad bank (base_offset).
// Optional feature macro HEQ_SEQ_TIMEOUT_EN: adds a per-state watchdog and an
// ERROR state that is left only through abort or rst. Without it the
// sequencer waits on done indefinitely and error stays 0.
module hist_eq_sequencer #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic               clock,
   input logic               rst,
   hist_eq_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE,
      HIST_RUN,
      HIST_REL,
      CDF_RUN,
      CDF_REL,
      MAP_RUN,
      MAP_REL,
      FINISH
`ifdef HEQ_SEQ_TIMEOUT_EN
      , ERROR
`endif
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic        hist_start_reg, hist_start_next;
   logic        cdf_start_reg, cdf_start_next;
   logic        map_start_reg, map_start_next;
   logic [1:0]  grant_reg, grant_next;
   logic        base_reg, base_next;
   logic        busy_reg, busy_next;
   logic        frame_done_reg, frame_done_next;
   logic [15:0] count_reg, count_next;
   logic        error_reg, error_next;

`ifdef HEQ_SEQ_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TIMER_W-1:0] timer_reg;
   logic               in_wait;
   logic               timeout_hit;

   assign in_wait = (state_reg == HIST_RUN) || (state_reg == HIST_REL) ||
                    (state_reg == CDF_RUN)  || (state_reg == CDF_REL)  ||
                    (state_reg == MAP_RUN)  || (state_reg == MAP_REL);
   assign timeout_hit = in_wait &&
                        (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: restart on every state change, count while waiting on an engine
   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         timer_reg <= '0;
      else if (state_next != state_reg)
         timer_reg <= '0;
      else if (in_wait)
         timer_reg <= timer_reg + 1'b1;
   end
`endif

   // State register
   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic: abort overrides everything, only the active engine's done is heard
   always_comb begin
      state_next = state_reg;
      if (bus.abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:     if (bus.go)         state_next = HIST_RUN;
            HIST_RUN: if (bus.hist_done)  state_next = HIST_REL;
            HIST_REL: if (!bus.hist_done) state_next = CDF_RUN;
            CDF_RUN:  if (bus.cdf_done)   state_next = CDF_REL;
            CDF_REL:  if (!bus.cdf_done)  state_next = MAP_RUN;
            MAP_RUN:  if (bus.map_done)   state_next = MAP_REL;
            MAP_REL:  if (!bus.map_done)  state_next = FINISH;
            FINISH:                       state_next = IDLE;
`ifdef HEQ_SEQ_TIMEOUT_EN
            ERROR:                        state_next = ERROR;
`endif
            default:                      state_next = IDLE;
         endcase
`ifdef HEQ_SEQ_TIMEOUT_EN
         if (timeout_hit)
            state_next = ERROR;
`endif
      end
   end

   // Output decode: starts/grant/busy/error follow the current state one edge
   // later; frame_done is decoded from the next state so it coincides with FINISH
   always_comb begin
      hist_start_next = 1'b0;
      cdf_start_next  = 1'b0;
      map_start_next  = 1'b0;
      grant_next      = 2'd0;
      busy_next       = (state_reg != IDLE);
      error_next      = 1'b0;
      frame_done_next = (state_next == FINISH);
      base_next       = base_reg;
      count_next      = count_reg;
      case (state_reg)
         HIST_RUN: begin hist_start_next = 1'b1; grant_next = 2'd1; end
         HIST_REL: grant_next = 2'd1;
         CDF_RUN:  begin cdf_start_next = 1'b1; grant_next = 2'd2; end
         CDF_REL:  grant_next = 2'd2;
         MAP_RUN:  begin map_start_next = 1'b1; grant_next = 2'd3; end
         MAP_REL:  grant_next = 2'd3;
         FINISH: begin
            // Leaving FINISH: next frame uses the other bank
            base_next  = ~base_reg;
            count_next = count_reg + 16'd1;
         end
`ifdef HEQ_SEQ_TIMEOUT_EN
         ERROR: error_next = 1'b1;
`endif
         default: ;
      endcase
      if (bus.abort) begin
         hist_start_next = 1'b0;
         cdf_start_next  = 1'b0;
         map_start_next  = 1'b0;
         grant_next      = 2'd0;
         busy_next       = 1'b0;
         error_next      = 1'b0;
         frame_done_next = 1'b0;
         base_next       = base_reg;
         count_next      = count_reg;
      end
   end

   // Output registers
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         hist_start_reg <= 1'b0;
         cdf_start_reg  <= 1'b0;
         map_start_reg  <= 1'b0;
         grant_reg      <= 2'd0;
         base_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         count_reg      <= 16'd0;
         error_reg      <= 1'b0;
      end else begin
         hist_start_reg <= hist_start_next;
         cdf_start_reg  <= cdf_start_next;
         map_start_reg  <= map_start_next;
         grant_reg      <= grant_next;
         base_reg       <= base_next;
         busy_reg       <= busy_next;
         frame_done_reg <= frame_done_next;
         count_reg      <= count_next;
         error_reg      <= error_next;
      end
   end

   assign bus.hist_start  = hist_start_reg;
   assign bus.cdf_start   = cdf_start_reg;
   assign bus.map_start   = map_start_reg;
   assign bus.m2_grant    = grant_reg;
   assign bus.base_offset = base_reg;
   assign bus.busy        = busy_reg;
   assign bus.frame_done  = frame_done_reg;
   assign bus.frame_count = count_reg;
   assign bus.error       = error_reg;

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Directed bench for hist_eq_sequencer: a frame table (engine latencies and
// expected frame length / count / bank) plus hand sequences for reset, abort,
// stray done and the watchdog.
module tb_hist_eq_sequencer;

   logic clock = 1'b0;
   logic rst   = 1'b1;

   hist_eq_sequencer_if bus();

   hist_eq_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;
   int last_fd  = 0;

   typedef struct {
      bit rst_before;
      int go_mode;      // 0 pulse, 1 hold and keep, 2 hold then release
      int lh, lc, lm;   // done latency after start seen
      int drop;         // done drop delay after start seen low
      bit stray;        // pulse foreign dones during HIST_RUN
      int exp_len;      // cycles from hist_start seen to frame_done seen
      int exp_count;
      int exp_base;
   } frame_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   function automatic logic start_of(input int e);
      case (e)
         1: return bus.hist_start;
         2: return bus.cdf_start;
         default: return bus.map_start;
      endcase
   endfunction

   function automatic int starts_high();
      return int'(bus.hist_start) + int'(bus.cdf_start) + int'(bus.map_start);
   endfunction

   task automatic set_done(input int e, input logic v);
      case (e)
         1: bus.hist_done = v;
         2: bus.cdf_done  = v;
         default: bus.map_done = v;
      endcase
   endtask

   task automatic wait_start(input int e, output int t_seen);
      int n = 0;
      while (start_of(e) !== 1'b1 && n < 40) begin tick(); n++; end
      check($sformatf("start%0d_rise", e), int'(start_of(e)), 1);
      t_seen = cyc;
   endtask

   // Engine responder: done after lat cycles, dropped drop cycles after start falls
   task automatic serve(input int e, input int lat, input int drop, input bit stray,
                        output int t_seen);
      int n;
      int bad = 0;
      wait_start(e, t_seen);
      check($sformatf("grant_run%0d", e), int'(bus.m2_grant), e);
      n = lat;
      if (stray && lat >= 2) begin
         bus.cdf_done = 1'b1; bus.map_done = 1'b1;
         tick();
         bus.cdf_done = 1'b0; bus.map_done = 1'b0;
         tick();
         check("stray_start", int'(bus.hist_start), 1);
         check("stray_grant", int'(bus.m2_grant), 1);
         check("stray_cdf_start", int'(bus.cdf_start), 0);
         n = lat - 2;
      end
      repeat (n) begin
         tick();
         if (starts_high() != 1 || bus.m2_grant != 2'(e)) bad++;
      end
      check($sformatf("run_stable%0d", e), bad, 0);
      set_done(e, 1'b1);
      n = 0;
      do begin tick(); n++; end while (start_of(e) !== 1'b0 && n < 40);
      check($sformatf("start%0d_fall", e), int'(start_of(e)), 0);
      check($sformatf("grant_rel%0d", e), int'(bus.m2_grant), e);
      repeat (drop) tick();
      set_done(e, 1'b0);
   endtask

   task automatic run_frame(input frame_t f, input int idx);
      int t_hs, t_tmp, t_fd, n;
      if (f.rst_before) begin
         bus.go = 1'b0;
         tick(); rst = 1'b1;
         tick(); rst = 1'b0;
      end
      if (f.go_mode == 0) begin
         bus.go = 1'b1; tick(); bus.go = 1'b0;
      end else begin
         bus.go = 1'b1;
      end
      serve(1, f.lh, f.drop, f.stray, t_hs);
      if (f.go_mode != 0 && !f.rst_before)
         check("idle_gap", t_hs - last_fd, 3);
      check("base_at_start", int'(bus.base_offset), f.exp_base ^ 1);
      serve(2, f.lc, f.drop, 1'b0, t_tmp);
      serve(3, f.lm, f.drop, 1'b0, t_tmp);
      n = 0;
      while (bus.frame_done !== 1'b1 && n < 20) begin tick(); n++; end
      check("frame_done_rise", int'(bus.frame_done), 1);
      t_fd = cyc;
      if (f.go_mode != 1) bus.go = 1'b0;
      check("frame_len", t_fd - t_hs, f.exp_len);
      tick();
      check("frame_done_pulse", int'(bus.frame_done), 0);
      check("grant_finish", int'(bus.m2_grant), 0);
      check("frame_count", int'(bus.frame_count), f.exp_count);
      check("base_offset", int'(bus.base_offset), f.exp_base);
      last_fd = t_fd;
      $display("frame %0d: len=%0d count=%0d base=%0d", idx, t_fd - t_hs,
               bus.frame_count, bus.base_offset);
   endtask

   initial begin
      frame_t tbl[6];
      frame_t extra;
      int t, n, bad;

      //        rst go  lh lc lm dr stray len cnt base
      tbl[0] = '{1, 0, 10, 5, 8, 3, 0, 43, 1, 1};
      tbl[1] = '{0, 0,  0, 0, 0, 0, 0, 11, 2, 0};
      tbl[2] = '{0, 0,  7, 1, 2, 5, 1, 36, 3, 1};
      tbl[3] = '{1, 1,  1, 2, 3, 1, 0, 20, 1, 1};
      tbl[4] = '{0, 1,  2, 2, 2, 0, 0, 17, 2, 0};
      tbl[5] = '{0, 2,  0, 4, 1, 2, 0, 22, 3, 1};

      bus.go = 1'b0; bus.abort = 1'b0;
      bus.hist_done = 1'b0; bus.cdf_done = 1'b0; bus.map_done = 1'b0;

      // Reset state, then idle with go low
      tick();
      check("rst_busy", int'(bus.busy), 0);
      check("rst_grant", int'(bus.m2_grant), 0);
      check("rst_starts", starts_high(), 0);
      check("rst_count", int'(bus.frame_count), 0);
      check("rst_base", int'(bus.base_offset), 0);
      check("rst_error", int'(bus.error), 0);
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         tick();
         if (bus.busy || bus.m2_grant != 2'd0 || bus.frame_done) bad++;
      end
      check("idle_quiet", bad, 0);
      $display("reset/idle: busy=%0d grant=%0d", bus.busy, bus.m2_grant);

      for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

      // Abort during CDF_RUN: bank and count must hold (count=3, base=1)
      bus.go = 1'b1; tick(); bus.go = 1'b0;
      serve(1, 2, 0, 1'b0, t);
      wait_start(2, t);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("abort_cdf_start", int'(bus.cdf_start), 0);
      check("abort_grant", int'(bus.m2_grant), 0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_count", int'(bus.frame_count), 3);
      check("abort_base", int'(bus.base_offset), 1);
      tick();
      check("abort_stays_idle", int'(bus.hist_start), 0);
      $display("abort: cdf_start=%0d grant=%0d count=%0d base=%0d",
               bus.cdf_start, bus.m2_grant, bus.frame_count, bus.base_offset);

      // Abort and go together in IDLE: abort wins
      bus.abort = 1'b1; bus.go = 1'b1; tick();
      bus.abort = 1'b0; bus.go = 1'b0; tick(); tick();
      check("abort_go_start", int'(bus.hist_start), 0);
      check("abort_go_busy", int'(bus.busy), 0);
      $display("abort+go: busy=%0d", bus.busy);

      // Asynchronous reset mid-frame, between clock edges
      bus.go = 1'b1; tick(); bus.go = 1'b0;
      serve(1, 3, 1, 1'b0, t);
      wait_start(2, t);
      #2 rst = 1'b1;
      #1;
      check("arst_cdf_start", int'(bus.cdf_start), 0);
      check("arst_grant", int'(bus.m2_grant), 0);
      check("arst_busy", int'(bus.busy), 0);
      check("arst_base", int'(bus.base_offset), 0);
      check("arst_count", int'(bus.frame_count), 0);
      $display("async reset: grant=%0d base=%0d count=%0d",
               bus.m2_grant, bus.base_offset, bus.frame_count);
      tick(); rst = 1'b0;

      // Normal frame after reset
      extra = '{0, 0, 3, 3, 3, 1, 0, 23, 1, 1};
      run_frame(extra, 6);

      // CDF engine never answers
      bus.go = 1'b1; tick(); bus.go = 1'b0;
      serve(1, 0, 0, 1'b0, t);
      wait_start(2, t);
`ifdef HEQ_SEQ_TIMEOUT_EN
      n = 0;
      while (bus.error !== 1'b1 && n < 40) begin tick(); n++; end
      check("timeout_cycles", n, 16);
      check("timeout_error", int'(bus.error), 1);
      check("timeout_starts", starts_high(), 0);
      check("timeout_grant", int'(bus.m2_grant), 0);
      check("timeout_busy", int'(bus.busy), 1);
      $display("timeout: after=%0d error=%0d", n, bus.error);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("timeout_abort_error", int'(bus.error), 0);
      check("timeout_abort_busy", int'(bus.busy), 0);
`else
      repeat (40) tick();
      check("wait_cdf_start", int'(bus.cdf_start), 1);
      check("wait_grant", int'(bus.m2_grant), 2);
      check("wait_error", int'(bus.error), 0);
      $display("no timeout: cdf_start=%0d grant=%0d", bus.cdf_start, bus.m2_grant);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("wait_abort_busy", int'(bus.busy), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/hist_eq_sequencer.md
# hist_eq_sequencer

Top-level phase controller for the histogram equalizer. It runs one frame through three engines in order: histogram count, CDF build, and pixel remap. It holds each engine's start/done handshake, decides which engine owns the m2 scratchpad ports, and ping-pongs the scratchpad bank select between frames. It sits above the input pipeline, CDF and remap engines and below the host/testbench `go` interface.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum cycles allowed in any RUN or REL state. Used only with the timeout feature.
- `clock` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: frame request, level-sensitive, sampled only in IDLE.
- `abort` in 1: synchronous abort. Highest priority after `rst`.
- `hist_start` out 1, `hist_done` in 1: histogram engine handshake.
- `cdf_start` out 1, `cdf_done` in 1: CDF engine handshake.
- `map_start` out 1, `map_done` in 1: remap engine handshake.
- `m2_grant` out 2: scratchpad owner. 0 = none, 1 = hist, 2 = cdf, 3 = map.
- `base_offset` out 1: scratchpad bank for the current frame; feeds each engine's `inputBaseOffset`.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `frame_count` out 16: completed frames, wraps modulo 2^16.
- `error` out 1: timeout flag. Only present with the timeout feature; otherwise tied 0.

## Operation
- Outputs are registered and decoded from the state register. Reset value of every output is 0; state resets to IDLE.
- IDLE: if `go`=1, move to HIST_RUN.
- X_RUN (X = HIST, CDF, MAP):
  - `X_start`=1 and `m2_grant`=X.
  - Wait for `X_done`=1, then move to X_REL.
- X_REL:
  - `X_start`=0; `m2_grant` stays X so in-flight pipeline writes drain.
  - Wait for `X_done`=0, since engines hold done until start drops and then return to reset.
  - Next state: HIST_REL goes to CDF_RUN, CDF_REL goes to MAP_RUN, MAP_REL goes to FINISH.
- FINISH (one cycle):
  - `frame_done`=1 and `m2_grant`=0.
  - On exit, `base_offset` toggles and `frame_count` increments.
  - Next state is IDLE.
- At most one `X_start` is high at any time. `m2_grant` never changes while an engine's start is high.
- `go` held high gives back-to-back frames, with exactly one IDLE cycle between FINISH and HIST_RUN.
- `go` outside IDLE is ignored. `go` falling mid-frame does not stop the frame.
- `abort`=1 in any state:
  - Next state is IDLE; all starts 0, grant 0, `error` 0.
  - `base_offset` and `frame_count` are unchanged.
  - `abort` and `go` high in the same cycle in IDLE: abort wins and the state stays IDLE.
- `rst` mid-frame: all outputs clear immediately (asynchronous); `base_offset` returns to 0.
- A `X_done` pulse from an engine other than the active one is ignored.

## Timing
- `go` sampled high in IDLE at edge N: `hist_start`=1 and `m2_grant`=1 after edge N+1.
- `X_done` sampled high at edge N: `X_start`=0 after edge N+1.
- `X_done` sampled low in REL at edge M: next `Y_start`=1 and `m2_grant`=Y after edge M+1.
- Minimum frame length is 7 cycles: 6 handshake states plus FINISH, excluding engine latency.
- `frame_done` rises at the same edge the state enters FINISH. `base_offset` and `frame_count` update one edge later.
- Timeout counter:
  - Clears on every state entry and increments each cycle in RUN/REL.
  - Reaching TIMEOUT_CYCLES-1 moves the state to ERROR on the next edge.

## Configuration
- `HEQ_SEQ_TIMEOUT_EN` defined:
  - Timeout counter and ERROR state are compiled in.
  - In ERROR: all starts 0, `m2_grant`=0, `busy`=1, `error`=1.
  - Leave ERROR only on `abort` or `rst`.
- Not defined: no counter and no ERROR state; `error` is tied 0. The sequencer waits indefinitely on done.

## Test plan
- Reset/idle: assert `rst` mid-cycle → all outputs 0 asynchronously. Release it and hold `go`=0 for 20 cycles → `busy`=0, `m2_grant`=0.
- Single frame: `go` pulse; engines return done after 10/5/8 cycles and drop it 3 cycles after start falls → grant sequence 1,2,3,0; one `frame_done` pulse; `frame_count`=1; `base_offset`=1.
- Back-to-back: hold `go` high for 3 frames → 3 `frame_done` pulses separated by exactly one IDLE cycle each; `base_offset` sequence 0,1,0,1; `frame_count`=3.
- Abort: `abort` during CDF_RUN → next cycle IDLE, `cdf_start`=0, grant 0, `frame_count` and `base_offset` unchanged. A following `go` completes a normal frame.
- Stray done: pulse `map_done` during HIST_RUN → no state change, grant stays 1.
- Timeout (with `HEQ_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=16): `cdf_done` never asserts → ERROR after 16 cycles in CDF_RUN, `error`=1, starts 0; `abort` → IDLE with `error`=0. Without the macro, the same stimulus keeps CDF_RUN indefinitely.
